// File: rtl/sub_multicycle_pkg.sv
// Shared definitions for the chunked multi-cycle subtractor: FSM state
// encodings and the counter-width helper.
package sub_multicycle_pkg;

  // Controller states; encodings are fixed so other arithmetic blocks can share them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the chunk counter. Returns 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Counter width for a given chunk count; never narrower than one bit.
  function automatic int cnt_width_f(input int nchunk);
    int r;
    r = clog2_f(nchunk);
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_multicycle_sub_chunk.sv
// W-bit combinational ripple-borrow subtractor: {bout, diff} = x - y - bin.
// The borrow chain is exactly W bits long, bounding the per-cycle path.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] borrow_chain_s;

  // Bit-serial full-subtractor chain, LSB first.
  always_comb begin
    diff              = {W{1'b0}};
    borrow_chain_s    = {(W+1){1'b0}};
    borrow_chain_s[0] = bin;
    for (int i = 0; i < W; i++) begin
      diff[i]             = x[i] ^ y[i] ^ borrow_chain_s[i];
      borrow_chain_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow_chain_s[i]);
    end
    bout = borrow_chain_s[W];
  end

endmodule

// File: rtl/sub_multicycle.sv
// Multi-cycle chunked subtractor: d = a - b - bi, W bits per clock, LSB
// chunk first, with valid/ready handshakes on operand and result sides.
// The chunk borrow is carried between cycles only through borrow_r.
module sub_multicycle
  import sub_multicycle_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bo
);

  localparam int NCHUNK = N / W;
  localparam int CNT_W  = cnt_width_f(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  // Reject configurations that cannot be split into whole chunks.
  if (W < 1 || (N % W) != 0) begin : g_bad_width
    $error("sub_multicycle: N (%0d) must be a positive multiple of W (%0d)", N, W);
  end

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [N-1:0]     d_r;
  logic             bo_r;
  logic             in_ready_r;
  logic             out_valid_r;

  int               base_s;
  logic [W-1:0]     x_s;
  logic [W-1:0]     y_s;
  logic [W-1:0]     diff_s;
  logic             bout_s;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    base_s = int'(cnt_r) * W;
    x_s    = a_r[base_s +: W];
    y_s    = b_r[base_s +: W];
  end

  sub_chunk #(
    .W (W)
  ) u_chunk (
    .x    (x_s),
    .y    (y_s),
    .bin  (borrow_r),
    .diff (diff_s),
    .bout (bout_s)
  );

  // Controller, operand capture, chunk accumulation and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      borrow_r    <= 1'b0;
      a_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      d_r         <= {N{1'b0}};
      bo_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            borrow_r   <= bi;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= ST_RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          d_r[base_s +: W] <= diff_s;
          borrow_r         <= bout_s;
          if (cnt_r == CNT_LAST) begin
            // Last chunk: its borrow is the overall borrow out.
            bo_r        <= bout_s;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Result held stable until the consumer takes it; no same-cycle re-accept.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign d         = d_r;
  assign bo        = bo_r;

endmodule

// File: tb/tb_sub_multicycle.sv
// Directed self-checking bench for sub_multicycle: a 32/8 instance for the
// directed vectors and an 8/4 instance for a wide sweep with consumer stalls.
module tb_sub_multicycle;

  logic        clk;
  logic        rst_n;

  logic        in_valid32, in_ready32, bi32, out_valid32, out_ready32, bo32;
  logic [31:0] a32, b32, d32;

  logic        in_valid8, in_ready8, bi8, out_valid8, out_ready8, bo8;
  logic [7:0]  a8, b8, d8;

  int errors;
  int checks;

  sub_multicycle #(.N(32), .W(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .bi(bi32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .d(d32), .bo(bo32)
  );

  sub_multicycle #(.N(8), .W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bi(bi8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .d(d8), .bo(bo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 32-bit instance with latency and handshake checks.
  task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic biv, input logic [31:0] exp_d, input logic exp_bo);
    int lat;
    check({tag, ".in_ready_before"}, 64'(in_ready32), 64'd1);
    in_valid32 = 1'b1; a32 = av; b32 = bv; bi32 = biv;
    tick();
    in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0; bi32 = 1'b0;
    check({tag, ".in_ready_run"}, 64'(in_ready32), 64'd0);
    lat = 0;
    while (!out_valid32 && lat < 20) begin
      tick();
      lat = lat + 1;
    end
    check({tag, ".latency"}, 64'(lat), 64'd4);
    check({tag, ".d"}, 64'(d32), 64'(exp_d));
    check({tag, ".bo"}, 64'(bo32), 64'(exp_bo));
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    check({tag, ".out_valid_after"}, 64'(out_valid32), 64'd0);
    check({tag, ".in_ready_after"}, 64'(in_ready32), 64'd1);
  endtask

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic        biv;
    logic [31:0] dv;
    logic        bov;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [8:0] exp9;
    logic [8:0] got9;
    int         lat;
    int         stall;

    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0; bi32 = 1'b0; out_ready32 = 1'b0;
    in_valid8  = 1'b0; a8  = 8'h0;  b8  = 8'h0;  bi8  = 1'b0; out_ready8  = 1'b0;

    // Reset for two edges.
    tick();
    tick();
    check("rst.in_ready", 64'(in_ready32), 64'd1);
    check("rst.out_valid", 64'(out_valid32), 64'd0);
    check("rst.d", 64'(d32), 64'd0);
    check("rst.bo", 64'(bo32), 64'd0);
    check("rst.in_ready8", 64'(in_ready8), 64'd1);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-RUN (chunk counter at 2) aborts the operation.
    in_valid32 = 1'b1; a32 = 32'h0000_0005; b32 = 32'h0000_0003; bi32 = 1'b0;
    tick();
    in_valid32 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort.in_ready", 64'(in_ready32), 64'd1);
    check("abort.out_valid", 64'(out_valid32), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort.no_result", 64'(out_valid32), 64'd0);
    end

    // Directed vectors with hand-computed results.
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0};
    vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run32($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].biv, vecs[i].dv, vecs[i].bov);
    end

    // Consumer stall: result must hold while inputs toggle.
    in_valid32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1111_1111; bi32 = 1'b0;
    tick();
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 20) begin
      tick();
      lat = lat + 1;
    end
    check("stall.latency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid32 = ~in_valid32;
      a32 = $urandom();
      b32 = $urandom();
      bi32 = ~bi32;
      tick();
      check("stall.d", 64'(d32), 64'h0123_4567);
      check("stall.bo", 64'(bo32), 64'd0);
      check("stall.out_valid", 64'(out_valid32), 64'd1);
      check("stall.in_ready", 64'(in_ready32), 64'd0);
    end
    in_valid32 = 1'b0; bi32 = 1'b0;
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    check("stall.release_in_ready", 64'(in_ready32), 64'd1);
    check("stall.release_out_valid", 64'(out_valid32), 64'd0);
    run32("after_stall", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);

    // 8/4 sweep: every a, b stepping by 17 (covers 0x00 and 0xFF), both bi.
    for (int ai = 0; ai < 256; ai++) begin
      for (int bj = 0; bj < 256; bj = bj + 17) begin
        for (int bk = 0; bk < 2; bk++) begin
          in_valid8 = 1'b1; a8 = 8'(ai); b8 = 8'(bj); bi8 = 1'(bk);
          exp9 = {1'b0, 8'(ai)} - {1'b0, 8'(bj)} - 9'(bk);
          tick();
          in_valid8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; bi8 = 1'b1;
          lat = 0;
          while (!out_valid8 && lat < 10) begin
            tick();
            lat = lat + 1;
          end
          if (lat != 2) begin
            check("sweep.latency", 64'(lat), 64'd2);
          end else begin
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
              tick();
            end
            got9 = {bo8, d8};
            check($sformatf("sweep a=%0d b=%0d bi=%0d", ai, bj, bk), 64'(got9), 64'(exp9));
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
            check("sweep.taken", 64'({out_valid8, in_ready8}), 64'b01);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
